multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the reduced RISC-V datapath, at the opposite end of the ALU interface. It fetches an instruction over a valid handshake, decodes addi/bne, and drives ALUctrl, ALUsrc, register addresses, the sign-extended immediate and RegWrite. It consumes the ALU EQ result to resolve bne and owns the program counter.

Parameters:
DATA_WIDTH, 32, immediate / datapath width.
ADDR_WIDTH, 32, PC width; PC arithmetic is modulo 2^ADDR_WIDTH.
CONTROL_SIGNAL, 1, ALUctrl width (0 = add, 1 = compare/subtract).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr  in  32  instruction word, sampled when instr_req && instr_valid.
instr_valid  in  1  instruction memory has a word for pc.
EQ  in  1  ALU equality flag (1 = operands equal).
instr_req  out  1  fetch request for address pc.
pc  out  ADDR_WIDTH  current instruction address.
ALUctrl  out  CONTROL_SIGNAL  ALU operation select.
ALUsrc  out  1  1 = op2 is imm, 0 = op2 is rs2 data.
rs1, rs2, rd  out  5 each  register-file addresses from the latched instruction.
imm  out  DATA_WIDTH  sign-extended immediate.
RegWrite  out  1  single-cycle register-file write strobe.
illegal  out  1  sticky flag: an unsupported instruction was seen.

Behaviour:
- Reset (rst_n low, async): state=FETCH, pc=RESET_PC, instr register=0, ALUctrl=0, ALUsrc=0, RegWrite=0, imm=0, rs1/rs2/rd=0, illegal=0, instr_req=0 while rst_n is low. Reset at any point, including mid-EXECUTE, aborts the instruction with no RegWrite and no PC update.
- FSM states: FETCH -> DECODE -> EXECUTE -> COMMIT -> FETCH.
- FETCH: instr_req=1. Stays in FETCH while instr_valid=0, with pc stable. On the edge where instr_valid=1, latch instr and go to DECODE.
- DECODE, one cycle, registered decode:
  - addi: opcode 0010011, funct3 000. imm = sext(instr[31:20]).
  - bne: opcode 1100011, funct3 001. imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Any other encoding is a NOP: imm=0, illegal set at the DECODE->EXECUTE edge.
  - rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] are valid from DECODE onward and held until the next fetch latch.
- EXECUTE, one cycle:
  - addi: ALUctrl=0, ALUsrc=1.
  - bne: ALUctrl=1, ALUsrc=0.
  - NOP: ALUctrl=0, ALUsrc=0.
  - EQ is registered at the EXECUTE->COMMIT edge. EQ is ignored in all other states.
- COMMIT, one cycle:
  - addi: RegWrite=1 for exactly this cycle, and only if rd != 0; pc <= pc+4.
  - bne: if registered EQ=0, pc <= pc+imm (offset relative to the branch's own pc); else pc <= pc+4.
  - NOP: pc <= pc+4, RegWrite=0.
- ALUctrl and ALUsrc hold their EXECUTE values through COMMIT and return to 0 in FETCH.
- Latency: 4 cycles per instruction when instr_valid is already high in FETCH. Each FETCH wait cycle adds one cycle.
- PC overflow wraps modulo 2^ADDR_WIDTH with no error. A misaligned branch target (bit1 set) is passed through unchecked.
- illegal clears only on reset.
- RegWrite is never asserted outside COMMIT.

Test Plan:
- Reset release, instr_valid=1, instr=0x00500093 (addi x1,x0,5) -> rd=1, rs1=0, imm=5; EXECUTE ALUctrl=0/ALUsrc=1; RegWrite=1 for exactly 1 cycle in COMMIT; pc goes 0->4 at the COMMIT exit; next instr_req 4 cycles after the first.
- pc=0x10, instr=0xFE209CE3 (bne x1,x2,-8), EQ=0 in EXECUTE -> imm=0xFFFFFFF8, ALUctrl=1, ALUsrc=0, pc=0x08, RegWrite never high.
- Same bne with EQ=1 in EXECUTE, and EQ toggled in other states -> pc=0x14; only the EXECUTE-cycle EQ matters.
- instr_valid held low 3 cycles in FETCH -> instr_req=1 throughout, state and pc unchanged; instruction completes 3 cycles later than baseline.
- instr=0x00000000 -> illegal=1 and stays 1 across further valid addi instructions; pc+4; no RegWrite.
- rst_n pulsed low during EXECUTE of an addi -> outputs return to 0 immediately (asynchronously); pc=RESET_PC; illegal=0; no RegWrite pulse; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the reduced RISC-V datapath.
// Fetches one instruction per pass through FETCH -> DECODE -> EXECUTE -> COMMIT.
// Decodes addi and bne, and treats any other encoding as a sticky-flagged NOP.
// Drives the ALU control, operand select, register addresses, immediate and
// register-file write strobe, and owns the program counter.
//
// Fetch handshake: instr_req is high for every FETCH cycle. A word is accepted
// on the rising edge where instr_req && instr_valid. When instr_valid is low,
// the FSM waits in FETCH with pc held. instr is ignored outside that edge.
module multicycle_ctrl #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    CONTROL_SIGNAL = 1,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [31:0]               instr,
   input  logic                      instr_valid,
   input  logic                      EQ,
   output logic                      instr_req,
   output logic [ADDR_WIDTH-1:0]     pc,
   output logic [CONTROL_SIGNAL-1:0] ALUctrl,
   output logic                      ALUsrc,
   output logic [4:0]                rs1,
   output logic [4:0]                rs2,
   output logic [4:0]                rd,
   output logic [DATA_WIDTH-1:0]     imm,
   output logic                      RegWrite,
   output logic                      illegal,
   output logic [1:0]                dbg_state
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DECODE  = 2'd1,
      EXECUTE = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_ADDI = 2'd1,
      OP_BNE  = 2'd2
   } op_t;

   localparam logic [6:0] OPC_ADDI = 7'b0010011;
   localparam logic [6:0] OPC_BNE  = 7'b1100011;
   localparam logic [2:0] F3_ADDI  = 3'b000;
   localparam logic [2:0] F3_BNE   = 3'b001;

   state_t                state_q;
   state_t                state_d;
   op_t                   op_q;
   op_t                   op_dec;
   logic [31:0]           instr_q;
   logic [DATA_WIDTH-1:0] imm_q;
   logic [DATA_WIDTH-1:0] imm_dec;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [ADDR_WIDTH-1:0] br_off;
   logic                  eq_q;
   logic                  illegal_q;
   logic                  fetch_fire;

   assign fetch_fire = (state_q == FETCH) && instr_valid;

   // Register fields come straight from the latched word so they are valid
   // from DECODE onward and stay put until the next fetch latch.
   assign rs1 = instr_q[19:15];
   assign rs2 = instr_q[24:20];
   assign rd  = instr_q[11:7];

   // Instruction class and sign-extended immediate of the latched word.
   always_comb begin
      op_dec  = OP_NOP;
      imm_dec = '0;
      if (instr_q[6:0] == OPC_ADDI && instr_q[14:12] == F3_ADDI) begin
         op_dec  = OP_ADDI;
         imm_dec = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
      end else if (instr_q[6:0] == OPC_BNE && instr_q[14:12] == F3_BNE) begin
         op_dec  = OP_BNE;
         imm_dec = {{(DATA_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};
      end
   end

   // Branch offset rebuilt at PC width so PC arithmetic never depends on
   // DATA_WIDTH; the sum simply wraps modulo 2^ADDR_WIDTH.
   assign br_off = {{(ADDR_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                    instr_q[30:25], instr_q[11:8], 1'b0};

   // PC value taken at the COMMIT exit; target alignment is not checked.
   always_comb begin
      pc_next = pc_q + ADDR_WIDTH'(4);
      if (op_q == OP_BNE && !eq_q) begin
         pc_next = pc_q + br_off;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one cycle per state except FETCH, which waits for a word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (instr_valid) state_d = DECODE;
         DECODE:  state_d = EXECUTE;
         EXECUTE: state_d = COMMIT;
         COMMIT:  state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // Instruction latch on the accepted fetch edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
      end else if (fetch_fire) begin
         instr_q <= instr;
      end
   end

   // Registered decode results and the sticky illegal flag, updated at the
   // DECODE -> EXECUTE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_NOP;
         imm_q     <= '0;
         illegal_q <= 1'b0;
      end else if (state_q == DECODE) begin
         op_q  <= op_dec;
         imm_q <= imm_dec;
         if (op_dec == OP_NOP) begin
            illegal_q <= 1'b1;
         end
      end
   end

   // ALU equality flag is only meaningful during EXECUTE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eq_q <= 1'b0;
      end else if (state_q == EXECUTE) begin
         eq_q <= EQ;
      end
   end

   // Program counter advances only when leaving COMMIT, so a reset anywhere
   // earlier in the instruction leaves no trace.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (state_q == COMMIT) begin
         pc_q <= pc_next;
      end
   end

   // Control outputs: ALU controls live in EXECUTE and COMMIT, the write strobe
   // only in COMMIT. The fetch request is gated by reset.
   always_comb begin
      instr_req = 1'b0;
      ALUctrl   = '0;
      ALUsrc    = 1'b0;
      RegWrite  = 1'b0;
      if (state_q == FETCH) begin
         instr_req = rst_n;
      end
      if (state_q == EXECUTE || state_q == COMMIT) begin
         if (op_q == OP_BNE) begin
            ALUctrl = CONTROL_SIGNAL'(1);
         end else if (op_q == OP_ADDI) begin
            ALUsrc = 1'b1;
         end
      end
      if (state_q == COMMIT && op_q == OP_ADDI && rd != 5'd0) begin
         RegWrite = 1'b1;
      end
   end

   assign pc        = pc_q;
   assign imm       = imm_q;
   assign illegal   = illegal_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by
// randomized instruction streams, checked against an instruction-level model.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        EQ;
   logic        instr_req;
   logic [31:0] pc;
   logic [0:0]  ALUctrl;
   logic        ALUsrc;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        RegWrite;
   logic        illegal;
   logic [1:0]  dbg_state;

   int tests_run = 0;
   int fail_cnt  = 0;
   int rw_count  = 0;

   logic [31:0] model_pc      = 32'h0;
   logic        model_illegal = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];

   multicycle_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .CONTROL_SIGNAL(1), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .EQ(EQ),
      .instr_req(instr_req), .pc(pc), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .RegWrite(RegWrite),
      .illegal(illegal), .dbg_state(dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Write-strobe counter and accepted-fetch address monitor.
   always @(negedge clk) begin
      if (RegWrite) rw_count++;
      if (rst_n && instr_req && instr_valid) got_q.push_back(pc);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: instruction class (0 nop, 1 addi, 2 bne).
   function automatic int kind_of(input logic [31:0] w);
      if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return 1;
      if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return 2;
      return 0;
   endfunction

   // Reference model: immediate value as a plain signed number.
   function automatic logic [31:0] imm_of(input logic [31:0] w);
      int v;
      case (kind_of(w))
         1: begin
            v = int'(w[31:20]);
            if (v >= 2048) v -= 4096;
         end
         2: begin
            v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048;
            if (w[31]) v -= 4096;
         end
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic logic [31:0] addi_word(input logic [11:0] i12, input logic [4:0] s1,
                                             input logic [4:0] d);
      return {i12, s1, 3'b000, d, 7'b0010011};
   endfunction

   function automatic logic [31:0] bne_word(input logic [12:0] o, input logic [4:0] s1,
                                            input logic [4:0] s2);
      return {o[12], o[10:5], s2, s1, 3'b001, o[4:1], o[11], 7'b1100011};
   endfunction

   // Driver: run one instruction from the first FETCH cycle to the next FETCH.
   // Entry and exit are 1 time unit after a rising edge with the DUT in FETCH.
   task automatic exec_instr(input logic [31:0] w, input int waits, input logic eq_val);
      int          k;
      int          rw0;
      logic [31:0] e_imm;
      logic [31:0] e_next;
      logic        e_rw;
      k      = kind_of(w);
      e_imm  = imm_of(w);
      e_rw   = (k == 1) && (w[11:7] != 5'd0);
      e_next = (k == 2 && !eq_val) ? model_pc + e_imm : model_pc + 32'd4;
      rw0    = rw_count;
      for (int i = 0; i < waits; i++) begin
         instr_valid = 1'b0;
         instr       = $urandom;
         EQ          = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("wait_req", instr_req, 1'b1);
         check("wait_pc", pc, model_pc);
         @(posedge clk); #1;
      end
      instr_valid = 1'b1;
      instr       = w;
      EQ          = 1'($urandom_range(0, 1));
      exp_q.push_back(model_pc);
      @(negedge clk);
      check("fetch_req", instr_req, 1'b1);
      check("fetch_pc", pc, model_pc);
      @(posedge clk); #1;
      // DECODE: inputs scrambled, EQ opposite to the EXECUTE value.
      instr_valid = 1'($urandom_range(0, 1));
      instr       = $urandom;
      EQ          = ~eq_val;
      @(negedge clk);
      check("dec_req", instr_req, 1'b0);
      check("dec_rs1", rs1, w[19:15]);
      check("dec_rs2", rs2, w[24:20]);
      check("dec_rd", rd, w[11:7]);
      check("dec_alu", {ALUctrl, ALUsrc}, 2'b00);
      check("dec_rw", RegWrite, 1'b0);
      @(posedge clk); #1;
      // EXECUTE
      EQ = eq_val;
      if (k == 0) model_illegal = 1'b1;
      @(negedge clk);
      check("ex_imm", imm, e_imm);
      check("ex_aluctrl", ALUctrl, (k == 2));
      check("ex_alusrc", ALUsrc, (k == 1));
      check("ex_illegal", illegal, model_illegal);
      check("ex_rw", RegWrite, 1'b0);
      check("ex_req", instr_req, 1'b0);
      @(posedge clk); #1;
      // COMMIT
      EQ = ~eq_val;
      @(negedge clk);
      check("cm_rw", RegWrite, e_rw);
      check("cm_aluctrl", ALUctrl, (k == 2));
      check("cm_alusrc", ALUsrc, (k == 1));
      check("cm_pc", pc, model_pc);
      check("cm_req", instr_req, 1'b0);
      @(posedge clk); #1;
      model_pc = e_next;
      instr_valid = 1'b0;
      check("rw_pulses", rw_count - rw0, e_rw ? 1 : 0);
      check("next_pc", pc, model_pc);
      check("next_alu", {ALUctrl, ALUsrc}, 2'b00);
   endtask

   // Driver: fetch an addi and pulse reset during its EXECUTE cycle.
   task automatic abort_addi(input logic [31:0] w);
      int rw0;
      rw0         = rw_count;
      instr_valid = 1'b1;
      instr       = w;
      exp_q.push_back(model_pc);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_req", instr_req, 1'b0);
      check("rst_alu", {ALUctrl, ALUsrc}, 2'b00);
      check("rst_imm", imm, 32'h0);
      check("rst_regs", {rs1, rs2, rd}, 15'h0);
      check("rst_illegal", illegal, 1'b0);
      check("rst_rw", RegWrite, 1'b0);
      @(posedge clk); #1;
      check("rst_hold_rw", RegWrite, 1'b0);
      check("rst_hold_pc", pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      model_pc      = 32'h0;
      model_illegal = 1'b0;
      check("rst_no_write", rw_count - rw0, 0);
      check("rst_restart_pc", pc, 32'h0);
      check("rst_restart_req", instr_req, 1'b1);
   endtask

   initial begin
      logic [31:0] w;
      int          r;
      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'h0;
      EQ          = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", pc, 32'h0);
      check("reset_req", instr_req, 1'b0);
      check("reset_alu", {ALUctrl, ALUsrc, RegWrite}, 3'b000);
      check("reset_imm", imm, 32'h0);
      check("reset_regs", {rs1, rs2, rd}, 15'h0);
      check("reset_illegal", illegal, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // addi x1,x0,5 then filler addis up to pc 0x10.
      exec_instr(32'h00500093, 0, 1'b0);
      check("addi_imm_held", imm, 32'h5);
      exec_instr(addi_word(12'hFFF, 5'd3, 5'd4), 0, 1'b1);
      exec_instr(addi_word(12'h7FF, 5'd1, 5'd0), 0, 1'b0);
      exec_instr(addi_word(12'h800, 5'd2, 5'd31), 0, 1'b1);
      // bne x1,x2,-8 at 0x10, not equal -> 0x08.
      exec_instr(32'hFE209CE3, 0, 1'b0);
      check("bne_taken_pc", pc, 32'h08);
      exec_instr(addi_word(12'h001, 5'd1, 5'd1), 0, 1'b0);
      exec_instr(addi_word(12'h002, 5'd1, 5'd1), 0, 1'b1);
      // Same bne at 0x10, equal -> 0x14.
      exec_instr(32'hFE209CE3, 0, 1'b1);
      check("bne_fall_pc", pc, 32'h14);
      // Three fetch wait cycles.
      exec_instr(addi_word(12'h010, 5'd5, 5'd6), 3, 1'b0);
      // All-zero word is illegal and the flag sticks.
      exec_instr(32'h00000000, 0, 1'b0);
      exec_instr(addi_word(12'h123, 5'd7, 5'd8), 1, 1'b0);
      exec_instr(addi_word(12'h321, 5'd8, 5'd9), 0, 1'b1);
      check("illegal_sticky", illegal, 1'b1);

      // Random stream.
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            w = addi_word(12'($urandom), 5'($urandom), 5'($urandom));
         end else if (r <= 7) begin
            w = bne_word(13'($urandom), 5'($urandom), 5'($urandom));
         end else if (r == 8) begin
            w = $urandom;
            w[6:0]   = 7'h13;
            w[14:12] = 3'($urandom_range(1, 7));
         end else begin
            w = $urandom;
         end
         exec_instr(w, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of an addi.
      abort_addi(addi_word(12'h055, 5'd1, 5'd10));

      // Wrap below zero, wrap above the top, misaligned target passed through.
      exec_instr(bne_word(13'h1FFC, 5'd0, 5'd1), 0, 1'b0);
      check("wrap_down_pc", pc, 32'hFFFFFFFC);
      exec_instr(addi_word(12'h001, 5'd0, 5'd2), 0, 1'b0);
      check("wrap_up_pc", pc, 32'h0);
      exec_instr(bne_word(13'h0002, 5'd3, 5'd4), 0, 1'b0);
      check("misaligned_pc", pc, 32'h2);
      exec_instr(addi_word(12'h004, 5'd1, 5'd1), 0, 1'b1);

      // Scoreboard: every accepted fetch address in order.
      check("fetch_count", got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         check("fetch_addr", got_q.pop_front(), exp_q.pop_front());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
